// File: rtl/display_pkg.sv
// Shared definitions for the 4-digit 7-segment display path (scheduler and segment decoder).
package display_pkg;
    localparam int DIGIT_COUNT = 4;

    localparam logic ANODE_OFF = 1'b1;
    localparam logic ANODE_ON  = 1'b0;

    // Digit slot order: slot 0 is the leftmost digit (an3), slot 3 the rightmost (an0).
    localparam logic [1:0] DIG_LEFT  = 2'd0;
    localparam logic [1:0] DIG_MIDL  = 2'd1;
    localparam logic [1:0] DIG_MIDR  = 2'd2;
    localparam logic [1:0] DIG_RIGHT = 2'd3;

    typedef logic [3:0] char_t;

    typedef enum logic [1:0] {
        PH_LOAD  = 2'd0,
        PH_BLANK = 2'd1,
        PH_ON    = 2'd2
    } phase_t;
endpackage

// File: rtl/display_scroll_scheduler_if.sv
// Host/button side and decoder side signals of the display scroll scheduler.
interface display_scroll_scheduler_if #(
    parameter int AW = 4
);
    import display_pkg::*;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    char_t         wr_data;
    logic          step;
    logic          auto_en;
    char_t         char_out;
    logic          an0;
    logic          an1;
    logic          an2;
    logic          an3;
    logic [AW-1:0] scroll_pos;
    logic          frame_done;

    modport master (
        output wr_en, wr_addr, wr_data, step, auto_en,
        input  char_out, an0, an1, an2, an3, scroll_pos, frame_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, step, auto_en,
        output char_out, an0, an1, an2, an3, scroll_pos, frame_done
    );
endinterface

// File: rtl/display_scroll_scheduler_scan_timer.sv
// Digit scan timing: slot tick and digit counters, LOAD/BLANK/ON phase decode, frame boundary.
module scan_timer
    import display_pkg::*;
#(
    parameter int DIGIT_TICKS = 16,
    parameter int BLANK_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] o_digit,
    output phase_t     o_phase,
    output logic [1:0] o_digit_nxt,
    output phase_t     o_phase_nxt,
    output logic       o_frame_end,
    output logic       o_frame_done
);
    localparam int TW = $clog2(DIGIT_TICKS);

    logic [TW-1:0] r_tick;
    logic [1:0]    r_digit;
    logic          r_frame_done;
    logic          w_tick_wrap;
    logic [TW-1:0] w_tick_nxt;

    function automatic phase_t phase_of(input logic [TW-1:0] t);
        if (t == '0)
            return PH_LOAD;
        else if (t < TW'(BLANK_TICKS))
            return PH_BLANK;
        else
            return PH_ON;
    endfunction

    assign w_tick_wrap = (r_tick == TW'(DIGIT_TICKS - 1));
    assign w_tick_nxt  = w_tick_wrap ? '0 : r_tick + 1'b1;
    assign o_digit_nxt = w_tick_wrap ? r_digit + 1'b1 : r_digit;
    assign o_phase_nxt = phase_of(w_tick_nxt);
    assign o_digit     = r_digit;
    assign o_phase     = phase_of(r_tick);
    assign o_frame_end = w_tick_wrap && (r_digit == DIG_RIGHT);
    assign o_frame_done = r_frame_done;

    // frame_done is registered from the next-state counters so it lines up with the last frame cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick       <= '0;
            r_digit      <= DIG_LEFT;
            r_frame_done <= 1'b0;
        end else begin
            r_tick       <= w_tick_nxt;
            r_digit      <= o_digit_nxt;
            r_frame_done <= (o_digit_nxt == DIG_RIGHT) && (w_tick_nxt == TW'(DIGIT_TICKS - 1));
        end
    end
endmodule

// File: rtl/display_scroll_scheduler.sv
// Multiplexes the 4-digit display from a 16-entry scrolling message buffer.
module display_scroll_scheduler
    import display_pkg::*;
#(
    parameter int MSG_DEPTH   = 16,
    parameter int DIGIT_TICKS = 16,
    parameter int BLANK_TICKS = 4,
    parameter int SCROLL_DIV  = 22
) (
    input  logic                         clk,
    input  logic                         reset,
    display_scroll_scheduler_if.slave    bus
);
    localparam int AW = $clog2(MSG_DEPTH);

    char_t                 r_buf [MSG_DEPTH];
    char_t                 r_char;
    logic [3:0]            r_an;
    logic [AW-1:0]         r_scroll;
    logic                  r_pending;
    logic [SCROLL_DIV-1:0] r_div;

    logic [1:0]    w_digit;
    logic [1:0]    w_digit_nxt;
    phase_t        w_phase;
    phase_t        w_phase_nxt;
    logic          w_frame_end;
    logic          w_frame_done;
    logic          w_auto_tick;
    logic          w_req;
    logic [AW-1:0] w_rd_addr;

    scan_timer #(
        .DIGIT_TICKS (DIGIT_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) u_scan (
        .clk          (clk),
        .reset        (reset),
        .o_digit      (w_digit),
        .o_phase      (w_phase),
        .o_digit_nxt  (w_digit_nxt),
        .o_phase_nxt  (w_phase_nxt),
        .o_frame_end  (w_frame_end),
        .o_frame_done (w_frame_done)
    );

    // Anode vector is {an3, an2, an1, an0}; slot d lights bit (3 - d).
    function automatic logic [3:0] anode_mask(input logic [1:0] digit, input logic on);
        logic [3:0] m;
        m = {DIGIT_COUNT{ANODE_OFF}};
        if (on)
            m[2'(DIGIT_COUNT - 1) - digit] = ANODE_ON;
        return m;
    endfunction

    assign w_auto_tick = bus.auto_en && (r_div == '1);
    assign w_req       = bus.step || w_auto_tick;
    assign w_rd_addr   = r_scroll + AW'(w_digit);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_DEPTH; i++)
                r_buf[i] <= '0;
        end else if (bus.wr_en) begin
            r_buf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Anodes follow the next-cycle phase so they are registered yet exact to the tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an   <= {DIGIT_COUNT{ANODE_OFF}};
            r_char <= '0;
        end else begin
            r_an <= anode_mask(w_digit_nxt, w_phase_nxt == PH_ON);
            if (w_phase == PH_LOAD)
                r_char <= r_buf[w_rd_addr];
        end
    end

    // Scroll requests collapse into one pending advance, applied only at the frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scroll  <= '0;
            r_pending <= 1'b0;
            r_div     <= '0;
        end else begin
            r_div <= bus.auto_en ? r_div + 1'b1 : '0;
            if (w_frame_end) begin
                if (r_pending || w_req)
                    r_scroll <= r_scroll + 1'b1;
                r_pending <= 1'b0;
            end else if (w_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign bus.char_out   = r_char;
    assign bus.an3        = r_an[3];
    assign bus.an2        = r_an[2];
    assign bus.an1        = r_an[1];
    assign bus.an0        = r_an[0];
    assign bus.scroll_pos = r_scroll;
    assign bus.frame_done = w_frame_done;
endmodule

// File: tb/tb_display_scroll_scheduler.sv
// Directed bench for display_scroll_scheduler: scan order, scrolling, buffer writes, reset.
module tb_display_scroll_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   tb_cyc = 0;

    logic [3:0] mbuf [16];
    logic [3:0] last_chars [4];

    display_scroll_scheduler_if bus_if ();

    display_scroll_scheduler #(
        .MSG_DEPTH   (16),
        .DIGIT_TICKS (16),
        .BLANK_TICKS (4),
        .SCROLL_DIV  (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Cycle index of the bench's own view of the scan, restarted by reset.
    always @(posedge clk) begin
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_addr = a;
        bus_if.wr_data = d;
        mbuf[a] = d;
        @(negedge clk);
        bus_if.wr_en = 1'b0;
    endtask

    task automatic sync_frame();
        int n = 0;
        while ((tb_cyc % 64) != 0 && n < 70) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Checks one full 64-cycle frame starting at the negedge of its first cycle.
    task automatic check_frame(input logic [3:0] pos, input logic [63:0] smask,
                               input int wcyc, input logic [3:0] wa, input logic [3:0] wd);
        logic [3:0] exp_an;
        logic [3:0] exp_ch = '0;
        int t;
        int d;
        for (int i = 0; i < 64; i++) begin
            t = i % 16;
            d = i / 16;
            chk("scroll_pos", bus_if.scroll_pos, pos);
            exp_an = 4'b1111;
            if (t >= 4) exp_an[3 - d] = 1'b0;
            chk("anodes", {bus_if.an3, bus_if.an2, bus_if.an1, bus_if.an0}, exp_an);
            chk("frame_done", bus_if.frame_done, (i == 63));
            if (t == 0) exp_ch = mbuf[(int'(pos) + d) % 16];
            else        chk("char_out", bus_if.char_out, exp_ch);
            if (t == 8) last_chars[d] = bus_if.char_out;
            bus_if.step = smask[i];
            if (i == wcyc) begin
                bus_if.wr_en   = 1'b1;
                bus_if.wr_addr = wa;
                bus_if.wr_data = wd;
                mbuf[wa] = wd;
            end else begin
                bus_if.wr_en = 1'b0;
            end
            @(negedge clk);
        end
        bus_if.step  = 1'b0;
        bus_if.wr_en = 1'b0;
    endtask

    initial begin
        logic [3:0] p;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_addr = '0;
        bus_if.wr_data = '0;
        bus_if.step    = 1'b0;
        bus_if.auto_en = 1'b0;
        for (int i = 0; i < 16; i++) mbuf[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_anodes", {bus_if.an3, bus_if.an2, bus_if.an1, bus_if.an0}, 4'b1111);
        chk("rst_char", bus_if.char_out, 4'h0);
        chk("rst_pos", bus_if.scroll_pos, 4'h0);
        chk("rst_fdone", bus_if.frame_done, 1'b0);

        // Scan order with a simple message
        wr(4'd0, 4'h1); wr(4'd1, 4'h4); wr(4'd2, 4'h3); wr(4'd3, 4'h5);
        wr(4'd4, 4'h7); wr(4'd14, 4'h9); wr(4'd15, 4'hC);
        sync_frame();
        check_frame(4'd0, 64'd0, -1, 4'd0, 4'd0);
        chk("t1_an3", last_chars[0], 4'h1);
        chk("t1_an2", last_chars[1], 4'h4);
        chk("t1_an1", last_chars[2], 4'h3);
        chk("t1_an0", last_chars[3], 4'h5);

        // Write during an2 ON holds char; then same-cycle write/LOAD collision
        check_frame(4'd0, 64'd0, 24, 4'd1, 4'hA);
        chk("t5_hold", last_chars[1], 4'h4);
        check_frame(4'd0, 64'd0, 32, 4'd2, 4'h6);
        chk("t5_newval", last_chars[1], 4'hA);
        chk("t5_collide_old", last_chars[2], 4'h3);

        // Single step mid-frame applies at the frame boundary
        check_frame(4'd0, 64'd1 << 10, -1, 4'd0, 4'd0);
        chk("t5_collide_new", last_chars[2], 4'h6);
        check_frame(4'd1, 64'd0, -1, 4'd0, 4'd0);
        chk("t2_d0", last_chars[0], 4'hA);
        chk("t2_d3", last_chars[3], 4'h7);

        // Several requests in one frame, including on frame_done, advance once
        check_frame(4'd1, (64'd1 << 5) | (64'd1 << 20) | (64'd1 << 40) | (64'd1 << 63), -1, 4'd0, 4'd0);
        check_frame(4'd2, 64'd0, -1, 4'd0, 4'd0);
        check_frame(4'd2, 64'd0, -1, 4'd0, 4'd0);

        // Auto-scroll: one advance per frame, wrapping 15 -> 0
        bus_if.auto_en = 1'b1;
        for (int k = 0; k < 15; k++) begin
            p = 4'(2 + k);
            check_frame(p, 64'd0, -1, 4'd0, 4'd0);
            if (p == 4'd14) begin
                chk("t4_win_an3", last_chars[0], 4'h9);
                chk("t4_win_an2", last_chars[1], 4'hC);
                chk("t4_win_an1", last_chars[2], 4'h1);
                chk("t4_win_an0", last_chars[3], 4'hA);
            end
        end
        bus_if.auto_en = 1'b0;
        check_frame(4'd1, 64'd0, -1, 4'd0, 4'd0);
        check_frame(4'd1, 64'd0, -1, 4'd0, 4'd0);

        // Reset in the middle of the an1 ON phase
        repeat (40) @(negedge clk);
        chk("t6_an1_on", {bus_if.an3, bus_if.an2, bus_if.an1, bus_if.an0}, 4'b1101);
        chk("t6_an1_char", bus_if.char_out, 4'h5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) mbuf[i] = '0;
        chk("t6_anodes", {bus_if.an3, bus_if.an2, bus_if.an1, bus_if.an0}, 4'b1111);
        chk("t6_char", bus_if.char_out, 4'h0);
        chk("t6_pos", bus_if.scroll_pos, 4'h0);
        chk("t6_fdone", bus_if.frame_done, 1'b0);
        check_frame(4'd0, 64'd0, -1, 4'd0, 4'd0);
        chk("t6_buf0", last_chars[0], 4'h0);
        chk("t6_buf1", last_chars[1], 4'h0);
        chk("t6_buf2", last_chars[2], 4'h0);
        chk("t6_buf3", last_chars[3], 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
